uart_receiver: RTL and testbench

- Receive-side peer of the UART transmitter. Consumes the serial line and produces bytes.
- Frame format is fixed at 1 start bit, 8 data bits LSB-first, 1 even-parity bit and 1 stop bit. Even parity means the parity bit equals the XOR of the 8 data bits.
- The line is oversampled 16x per bit. Each received byte is presented with a 1-cycle valid strobe plus parity and framing error flags.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_rx_sample_gen.sv | 42 ++++
 rtl/uart_receiver.sv | 147 ++++++++++++++
 tb/tb_uart_receiver.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud codes
// and the oversample divisor helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    int unsigned r;
    case (sel)
      BAUD_300:    r = 300;
      BAUD_1200:   r = 1200;
      BAUD_4800:   r = 4800;
      BAUD_9600:   r = 9600;
      BAUD_19200:  r = 19200;
      BAUD_38400:  r = 38400;
      BAUD_57600:  r = 57600;
      default:     r = 115200;
    endcase
    return r;
  endfunction

  // Rounded clk/(16*baud)
  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_rx_sample_gen.sv
// 16x oversample tick divider; restarts on request or on any
// baud_select change.
module uart_rx_sample_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_baud_select,
  input  logic       i_restart,
  output logic       o_tick
);

  localparam int unsigned DIV_MAX = baud_div(CLK_FREQ_HZ, 300);
  localparam int DIV_W = $clog2(DIV_MAX + 1);

  logic [DIV_W-1:0] w_last [8];
  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             w_restart;

  for (genvar g = 0; g < 8; g++) begin : g_div
    assign w_last[g] =
      DIV_W'(baud_div(CLK_FREQ_HZ, baud_rate(3'(g))) - 1);
  end

  assign w_restart = i_restart | (i_baud_select != r_sel);
  assign o_tick    = (r_cnt == w_last[i_baud_select]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sel <= BAUD_300;
    end else begin
      r_sel <= i_baud_select;
      if (w_restart || o_tick) r_cnt <= '0;
      else                     r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8E1 frames, 16x oversampling, 1-cycle valid
// strobe with parity and framing flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  rx_state_e  r_state, w_nstate;
  logic [3:0] r_cnt, w_ncnt;
  logic [2:0] r_idx, w_nidx;
  logic [7:0] r_shreg, w_nshreg;
  logic       r_par, w_npar;
  logic       r_sync1, r_sync2;
  logic       w_rxs, w_tick, w_restart, w_upd;

  assign w_rxs     = r_sync2;
  assign w_restart = (w_nstate == ST_IDLE) && (r_state != ST_IDLE);
  assign Rx_BUSY   = r_state inside {ST_START, ST_DATA,
                                     ST_PARITY, ST_STOP};

  uart_rx_sample_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_gen (
    .clk          (clk),
    .reset        (reset),
    .i_baud_select(baud_select),
    .i_restart    (w_restart),
    .o_tick       (w_tick)
  );

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nidx   = r_idx;
    w_nshreg = r_shreg;
    w_npar   = r_par;
    w_upd    = 1'b0;
    if (!Rx_EN) begin
      w_nstate = ST_OFF;
    end else begin
      unique case (r_state)
        ST_OFF: w_nstate = ST_IDLE;
        ST_IDLE: begin
          if (w_tick && !w_rxs) begin
            w_nstate = ST_START;
            w_ncnt   = '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_cnt == MID_TICK) begin
              w_ncnt   = '0;
              w_nidx   = '0;
              w_nstate = w_rxs ? ST_IDLE : ST_DATA;
            end else begin
              w_ncnt = r_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_cnt == LAST_TICK) begin
              w_nshreg[r_idx] = w_rxs;
              w_ncnt = '0;
              if (r_idx == 3'd7) w_nstate = ST_PARITY;
              else               w_nidx   = r_idx + 3'd1;
            end else begin
              w_ncnt = r_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            if (r_cnt == LAST_TICK) begin
              w_npar   = w_rxs;
              w_ncnt   = '0;
              w_nstate = ST_STOP;
            end else begin
              w_ncnt = r_cnt + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_cnt == LAST_TICK) begin
              w_upd    = 1'b1;
              w_ncnt   = '0;
              w_nstate = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              w_ncnt = r_cnt + 4'd1;
            end
          end
        end
        // A held-low line must not look like a new start bit
        ST_WAIT_HIGH: if (w_tick && w_rxs) w_nstate = ST_IDLE;
        default: w_nstate = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      r_sync1  <= RxD;
      r_sync2  <= r_sync1;
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_idx    <= w_nidx;
      r_shreg  <= w_nshreg;
      r_par    <= w_npar;
      Rx_VALID <= w_upd;
      if (w_upd) begin
        Rx_DATA   <= r_shreg;
        Rx_PERROR <= r_par ^ (^r_shreg);
        Rx_FERROR <= ~w_rxs;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at 115200 baud,
// 50 MHz (27 clk per tick, 432 clk per bit).
module tb_uart_receiver;

  localparam int TICK = 27;
  localparam int BIT  = 16 * TICK;

  logic       clk;
  logic       reset;
  logic       RxD;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;
  logic       Rx_BUSY;

  int checks;
  int errors;
  int vcnt;
  int busy_cnt;
  int err_any;
  logic [7:0] vlog [8];

  uart_receiver #(
    .CLK_FREQ_HZ(50_000_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .baud_select(baud_select),
    .Rx_EN      (Rx_EN),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_FERROR  (Rx_FERROR),
    .Rx_BUSY    (Rx_BUSY)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (Rx_BUSY) busy_cnt <= busy_cnt + 1;
    if (Rx_VALID) begin
      if (vcnt < 8) vlog[vcnt] <= Rx_DATA;
      vcnt <= vcnt + 1;
      if (Rx_PERROR || Rx_FERROR) err_any <= err_any + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clr();
    vcnt     = 0;
    busy_cnt = 0;
    err_any  = 0;
  endtask

  // Line is left at the stop-bit level afterwards
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      RxD = f[i];
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    RxD = 1'b1;
    Rx_EN = 1'b0;
    baud_select = 3'b111;
    #35;
    checks++;
    if (Rx_DATA !== 8'h00) begin errors++;
      $display("FAIL rst_data got %h want 00", Rx_DATA); end
    checks++;
    if (Rx_VALID !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b want 0", Rx_VALID); end
    checks++;
    if (Rx_PERROR !== 1'b0) begin errors++;
      $display("FAIL rst_perr got %b want 0", Rx_PERROR); end
    checks++;
    if (Rx_FERROR !== 1'b0) begin errors++;
      $display("FAIL rst_ferr got %b want 0", Rx_FERROR); end
    checks++;
    if (Rx_BUSY !== 1'b0) begin errors++;
      $display("FAIL rst_busy got %b want 0", Rx_BUSY); end
    @(negedge clk);
    reset = 1'b1;
    idle(5);
    Rx_EN = 1'b1;
    idle(BIT);
  endtask

  task automatic test_basic();
    clr();
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(BIT);
    checks++;
    if (vcnt !== 1) begin errors++;
      $display("FAIL basic_vcnt got %0d want 1", vcnt); end
    checks++;
    if (Rx_DATA !== 8'hA5) begin errors++;
      $display("FAIL basic_data got %h want a5", Rx_DATA); end
    checks++;
    if (Rx_PERROR !== 1'b0 || Rx_FERROR !== 1'b0) begin errors++;
      $display("FAIL basic_flags got %b%b want 00",
               Rx_PERROR, Rx_FERROR); end
    // START..STOP spans 8+16*10 = 168 ticks
    checks++;
    if (busy_cnt !== 168 * TICK) begin errors++;
      $display("FAIL basic_busy got %0d want %0d",
               busy_cnt, 168 * TICK); end
  endtask

  task automatic test_parity();
    clr();
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(BIT);
    checks++;
    if (Rx_DATA !== 8'h3C) begin errors++;
      $display("FAIL par_data got %h want 3c", Rx_DATA); end
    checks++;
    if (Rx_PERROR !== 1'b1 || Rx_FERROR !== 1'b0) begin errors++;
      $display("FAIL par_bad_flags got %b%b want 10",
               Rx_PERROR, Rx_FERROR); end
    send_frame(8'h01, 1'b1, 1'b1);
    idle(BIT);
    checks++;
    if (Rx_DATA !== 8'h01) begin errors++;
      $display("FAIL par_data2 got %h want 01", Rx_DATA); end
    checks++;
    if (Rx_PERROR !== 1'b0) begin errors++;
      $display("FAIL par_ok got %b want 0", Rx_PERROR); end
    checks++;
    if (vcnt !== 2) begin errors++;
      $display("FAIL par_vcnt got %0d want 2", vcnt); end
  endtask

  task automatic test_framing();
    clr();
    send_frame(8'h55, 1'b0, 1'b0);
    idle(3 * BIT);
    checks++;
    if (Rx_FERROR !== 1'b1) begin errors++;
      $display("FAIL frm_ferr got %b want 1", Rx_FERROR); end
    checks++;
    if (Rx_DATA !== 8'h55 || Rx_PERROR !== 1'b0) begin errors++;
      $display("FAIL frm_data got %h/%b want 55/0",
               Rx_DATA, Rx_PERROR); end
    checks++;
    if (Rx_BUSY !== 1'b0) begin errors++;
      $display("FAIL frm_low_busy got %b want 0", Rx_BUSY); end
    @(negedge clk);
    RxD = 1'b1;
    idle(BIT);
    checks++;
    if (vcnt !== 1) begin errors++;
      $display("FAIL frm_vcnt got %0d want 1", vcnt); end
    send_frame(8'h12, 1'b0, 1'b1);
    idle(BIT);
    checks++;
    if (vcnt !== 2 || Rx_DATA !== 8'h12) begin errors++;
      $display("FAIL frm_next got %0d/%h want 2/12",
               vcnt, Rx_DATA); end
    checks++;
    if (Rx_FERROR !== 1'b0) begin errors++;
      $display("FAIL frm_ferr_clr got %b want 0", Rx_FERROR); end
  endtask

  task automatic test_glitch();
    clr();
    @(negedge clk);
    RxD = 1'b0;
    repeat (4 * TICK) @(negedge clk);
    RxD = 1'b1;
    idle(2 * BIT);
    checks++;
    if (vcnt !== 0) begin errors++;
      $display("FAIL glitch_vcnt got %0d want 0", vcnt); end
    // START lasts exactly 8 ticks before the glitch is rejected
    checks++;
    if (busy_cnt !== 8 * TICK || Rx_BUSY !== 1'b0) begin errors++;
      $display("FAIL glitch_busy got %0d/%b want %0d/0",
               busy_cnt, Rx_BUSY, 8 * TICK); end
    send_frame(8'h81, 1'b0, 1'b1);
    idle(BIT);
    checks++;
    if (vcnt !== 1 || Rx_DATA !== 8'h81) begin errors++;
      $display("FAIL glitch_next got %0d/%h want 1/81",
               vcnt, Rx_DATA); end
  endtask

  task automatic test_disable();
    logic [10:0] f;
    clr();
    f = {1'b1, 1'b0, 8'hF0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      RxD = f[i];
      if (i == 5) begin
        repeat (BIT / 2) @(negedge clk);
        Rx_EN = 1'b0;
        repeat (BIT / 2 - 1) @(negedge clk);
      end else begin
        repeat (BIT - 1) @(negedge clk);
      end
    end
    idle(BIT);
    checks++;
    if (vcnt !== 0 || Rx_BUSY !== 1'b0) begin errors++;
      $display("FAIL dis_quiet got %0d/%b want 0/0",
               vcnt, Rx_BUSY); end
    checks++;
    if (Rx_DATA !== 8'h81) begin errors++;
      $display("FAIL dis_hold got %h want 81", Rx_DATA); end
    @(negedge clk);
    Rx_EN = 1'b1;
    idle(BIT);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(BIT);
    checks++;
    if (vcnt !== 1 || Rx_DATA !== 8'h0F) begin errors++;
      $display("FAIL dis_reen got %0d/%h want 1/0f",
               vcnt, Rx_DATA); end
  endtask

  task automatic test_back_to_back();
    clr();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(BIT);
    checks++;
    if (vcnt !== 3) begin errors++;
      $display("FAIL b2b_vcnt got %0d want 3", vcnt); end
    checks++;
    if (vlog[0] !== 8'h00) begin errors++;
      $display("FAIL b2b_d0 got %h want 00", vlog[0]); end
    checks++;
    if (vlog[1] !== 8'hFF) begin errors++;
      $display("FAIL b2b_d1 got %h want ff", vlog[1]); end
    checks++;
    if (vlog[2] !== 8'h7E) begin errors++;
      $display("FAIL b2b_d2 got %h want 7e", vlog[2]); end
    checks++;
    if (err_any !== 0) begin errors++;
      $display("FAIL b2b_err got %0d want 0", err_any); end
  endtask

  task automatic test_reset_mid();
    clr();
    @(negedge clk);
    RxD = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    checks++;
    if (Rx_BUSY !== 1'b1) begin errors++;
      $display("FAIL rmid_busy_pre got %b want 1", Rx_BUSY); end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (Rx_DATA !== 8'h00 || Rx_BUSY !== 1'b0) begin errors++;
      $display("FAIL rmid_async got %h/%b want 00/0",
               Rx_DATA, Rx_BUSY); end
    checks++;
    if ({Rx_VALID, Rx_PERROR, Rx_FERROR} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_flags got %b want 000",
               {Rx_VALID, Rx_PERROR, Rx_FERROR}); end
    idle(10);
    @(negedge clk);
    RxD = 1'b1;
    reset = 1'b1;
    idle(2 * BIT);
    checks++;
    if (vcnt !== 0) begin errors++;
      $display("FAIL rmid_vcnt got %0d want 0", vcnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_disable();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
